// File: rtl/pid_ctrl_param_if.sv
// Drive-path bus for the PID steering controller: heading error in, wheel speeds out.
// master = error source / consumer side, slave = controller side.
interface pid_ctrl_param_if #(
  parameter int ERR_W = 12,
  parameter int SPD_W = 11
);
  logic signed [ERR_W-1:0] error;
  logic                    err_vld;
  logic                    moving;
  logic [SPD_W-2:0]        frwrd;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    spd_vld;

  modport master (
    output error, err_vld, moving, frwrd,
    input  lft_spd, rght_spd, spd_vld
  );

  modport slave (
    input  error, err_vld, moving, frwrd,
    output lft_spd, rght_spd, spd_vld
  );
endinterface

// File: rtl/pid_ctrl_param.sv
// Three-stage pipelined PID steering controller producing clamped left/right wheel speeds.
// Define PID_I_SAT_EN to clamp the integrator on overflow instead of holding it.
module pid_ctrl_param #(
  parameter int ERR_W   = 12,
  parameter int SAT_W   = 10,
  parameter int SPD_W   = 11,
  parameter int INT_W   = 15,
  parameter int I_SHIFT = 6,
  parameter int P_COEFF = 16,
  parameter int D_COEFF = 7,
  parameter int D_SAT_W = 8,
  parameter int D_DLY   = 3
) (
  input logic             clk,
  input logic             rst_n,
  pid_ctrl_param_if.slave bus
);

  localparam int SUM_W  = SAT_W + 8;
  localparam int DIFF_W = SAT_W + 1;

  localparam logic signed [SAT_W-1:0]   SAT_MAX = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0]   SAT_MIN = {1'b1, {(SAT_W-1){1'b0}}};
  localparam logic signed [D_SAT_W-1:0] DS_MAX  = {1'b0, {(D_SAT_W-1){1'b1}}};
  localparam logic signed [D_SAT_W-1:0] DS_MIN  = {1'b1, {(D_SAT_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]   P_K     = SUM_W'(P_COEFF);
  localparam logic signed [SUM_W-1:0]   D_K     = SUM_W'(D_COEFF);
  localparam logic signed [SUM_W-1:0]   SPD_LIM = SUM_W'((1 << (SPD_W-1)) - 1);
  localparam logic signed [SUM_W-1:0]   SPD_NEG = -SPD_LIM;

  // ---------------- stage A: input capture ----------------
  logic signed [ERR_W-1:0] error_a_reg;
  logic                    vld_a_reg;
  logic                    moving_a_reg;
  logic [SPD_W-2:0]        frwrd_a_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_a_reg  <= '0;
      vld_a_reg    <= 1'b0;
      moving_a_reg <= 1'b0;
      frwrd_a_reg  <= '0;
    end else begin
      error_a_reg  <= bus.error;
      vld_a_reg    <= bus.err_vld;
      moving_a_reg <= bus.moving;
      frwrd_a_reg  <= bus.frwrd;
    end
  end

  // ---------------- stage B: P, I, D terms ----------------
  logic signed [SAT_W-1:0] err_sat;

  // In range when every bit above the target sign bit matches it
  always_comb begin
    err_sat = error_a_reg[SAT_W-1:0];
    if (!(&error_a_reg[ERR_W-1:SAT_W-1]) && (|error_a_reg[ERR_W-1:SAT_W-1]))
      err_sat = error_a_reg[ERR_W-1] ? SAT_MIN : SAT_MAX;
  end

  logic signed [INT_W-1:0] integ_reg;
  logic signed [INT_W-1:0] integ_next;
  logic signed [INT_W-1:0] integ_add;
  logic signed [INT_W-1:0] err_ext_i;
  logic                    integ_ovf;

  assign err_ext_i = {{(INT_W-SAT_W){err_sat[SAT_W-1]}}, err_sat};
  assign integ_add = integ_reg + err_ext_i;
  assign integ_ovf = (integ_reg[INT_W-1] == err_ext_i[INT_W-1]) &&
                     (integ_add[INT_W-1] != integ_reg[INT_W-1]);

  always_comb begin
    integ_next = integ_reg;
    if (!moving_a_reg) begin
      integ_next = '0;
    end else if (vld_a_reg) begin
      if (!integ_ovf) begin
        integ_next = integ_add;
      end
`ifdef PID_I_SAT_EN
      else begin
        integ_next = integ_reg[INT_W-1] ? {1'b1, {(INT_W-1){1'b0}}}
                                        : {1'b0, {(INT_W-1){1'b1}}};
      end
`endif
    end
  end

  // Derivative history: hist_reg[0] is the newest valid sample
  logic signed [SAT_W-1:0] hist_reg [D_DLY];
  logic signed [SAT_W-1:0] hist_in  [D_DLY];

  for (genvar gi = 0; gi < D_DLY; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign hist_in[gi] = err_sat;
    end else begin : g_tail
      assign hist_in[gi] = hist_reg[gi-1];
    end
  end

  logic signed [DIFF_W-1:0]  diff;
  logic signed [D_SAT_W-1:0] diff_sat;

  assign diff = {err_sat[SAT_W-1], err_sat} -
                {hist_reg[D_DLY-1][SAT_W-1], hist_reg[D_DLY-1]};

  always_comb begin
    diff_sat = diff[D_SAT_W-1:0];
    if (!(&diff[DIFF_W-1:D_SAT_W-1]) && (|diff[DIFF_W-1:D_SAT_W-1]))
      diff_sat = diff[DIFF_W-1] ? DS_MIN : DS_MAX;
  end

  logic signed [SUM_W-1:0] err_ext_s;
  logic signed [SUM_W-1:0] diff_ext;
  logic signed [SUM_W-1:0] p_prod;
  logic signed [INT_W-1:0] i_sh;
  logic signed [SUM_W-1:0] p_next;
  logic signed [SUM_W-1:0] i_next;
  logic signed [SUM_W-1:0] d_next;

  assign err_ext_s = {{(SUM_W-SAT_W){err_sat[SAT_W-1]}}, err_sat};
  assign diff_ext  = {{(SUM_W-D_SAT_W){diff_sat[D_SAT_W-1]}}, diff_sat};
  assign p_prod    = err_ext_s * P_K;
  assign p_next    = p_prod >>> 1;
  assign i_sh      = integ_next >>> I_SHIFT;
  assign i_next    = {{(SUM_W-INT_W){i_sh[INT_W-1]}}, i_sh};
  assign d_next    = diff_ext * D_K;

  logic signed [SUM_W-1:0] p_reg;
  logic signed [SUM_W-1:0] i_reg;
  logic signed [SUM_W-1:0] d_reg;
  logic                    vld_b_reg;
  logic                    moving_b_reg;
  logic [SPD_W-2:0]        frwrd_b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_reg    <= '0;
      hist_reg     <= '{default: '0};
      p_reg        <= '0;
      i_reg        <= '0;
      d_reg        <= '0;
      vld_b_reg    <= 1'b0;
      moving_b_reg <= 1'b0;
      frwrd_b_reg  <= '0;
    end else begin
      integ_reg <= integ_next;
      if (vld_a_reg)
        hist_reg <= hist_in;
      p_reg        <= p_next;
      i_reg        <= i_next;
      d_reg        <= d_next;
      vld_b_reg    <= vld_a_reg;
      moving_b_reg <= moving_a_reg;
      frwrd_b_reg  <= frwrd_a_reg;
    end
  end

  // ---------------- stage C: wheel speeds ----------------
  function automatic logic signed [SPD_W-1:0] clamp_spd(input logic signed [SUM_W-1:0] x);
    if (x > SPD_LIM)
      return SPD_LIM[SPD_W-1:0];
    else if (x < SPD_NEG)
      return SPD_NEG[SPD_W-1:0];
    else
      return x[SPD_W-1:0];
  endfunction

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] pid;
  logic signed [SUM_W-1:0] frwrd_ext;
  logic signed [SUM_W-1:0] lft_raw;
  logic signed [SUM_W-1:0] rght_raw;

  assign sum       = p_reg + i_reg + d_reg;
  assign pid       = sum >>> 3;
  assign frwrd_ext = {{(SUM_W-SPD_W+1){1'b0}}, frwrd_b_reg};
  assign lft_raw   = frwrd_ext + pid;
  assign rght_raw  = frwrd_ext - pid;

  logic signed [SPD_W-1:0] lft_reg;
  logic signed [SPD_W-1:0] rght_reg;
  logic                    spd_vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_reg     <= '0;
      rght_reg    <= '0;
      spd_vld_reg <= 1'b0;
    end else begin
      lft_reg     <= moving_b_reg ? clamp_spd(lft_raw)  : '0;
      rght_reg    <= moving_b_reg ? clamp_spd(rght_raw) : '0;
      spd_vld_reg <= vld_b_reg;
    end
  end

  assign bus.lft_spd  = lft_reg;
  assign bus.rght_spd = rght_reg;
  assign bus.spd_vld  = spd_vld_reg;

endmodule
